// File: rtl/pause_fade_ctrl.sv
// pause_fade_ctrl: merges button, external requests and OSD state into one
// registered CPU pause, then fades the video in timed steps while paused.
module pause_fade_ctrl #(
  parameter int unsigned RW          = 3,
  parameter int unsigned GW          = 3,
  parameter int unsigned BW          = 2,
  parameter int unsigned NREQ        = 2,
  parameter int unsigned TICK_CYCLES = 6000000,
  parameter int unsigned DIM_TICKS   = 40,
  parameter int unsigned DIM_MAX     = 1
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic                  user_button,
  input  logic [NREQ-1:0]       pause_request,
  input  logic                  OSD_STATUS,
  input  logic [1:0]            options,
  input  logic [RW-1:0]         r,
  input  logic [GW-1:0]         g,
  input  logic [BW-1:0]         b,
  output logic                  pause_cpu,
  output logic [NREQ+1:0]       pause_src,
  output logic [1:0]            dim_level,
  output logic [RW+GW+BW-1:0]   rgb_out
);

  localparam int unsigned CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int unsigned TW = (DIM_TICKS > 0) ? $clog2(DIM_TICKS + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    FADE = 2'd2
  } state_t;

  state_t          state;
  logic            btn_d;
  logic            user_pause;
  logic [CW-1:0]   cyc_cnt;
  logic [TW-1:0]   tick_cnt;

  logic            user_pause_next;
  logic [NREQ+1:0] src_next;
  logic            pause_next;
  logic            tick;
  logic [TW-1:0]   tick_cnt_next;

  // Next-state pause sources and fade tick decode
  always_comb begin
    user_pause_next = user_pause ^ (user_button & ~btn_d);
    src_next        = {OSD_STATUS & options[0], user_pause_next, pause_request};
    pause_next      = |src_next;
    tick            = (cyc_cnt == CW'(TICK_CYCLES - 1));
    tick_cnt_next   = tick_cnt;
    if (tick && (tick_cnt != TW'(DIM_TICKS)))
      tick_cnt_next = tick_cnt + 1'b1;
  end

  // Pause merge, fade FSM and dimmed video register.
  // The FSM follows the next-state pause so that the first fade step lands
  // exactly DIM_TICKS*TICK_CYCLES cycles after pause_cpu rises, and dim_level
  // clears on the same edge that pause_cpu falls.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      btn_d      <= 1'b1;
      user_pause <= 1'b0;
      pause_src  <= '0;
      pause_cpu  <= 1'b0;
      dim_level  <= '0;
      rgb_out    <= '0;
      state      <= IDLE;
      cyc_cnt    <= '0;
      tick_cnt   <= '0;
    end else begin
      btn_d      <= user_button;
      user_pause <= user_pause_next;
      pause_src  <= src_next;
      pause_cpu  <= pause_next;
      rgb_out    <= {r >> dim_level, g >> dim_level, b >> dim_level};

      if (!pause_next) begin
        state     <= IDLE;
        dim_level <= '0;
        cyc_cnt   <= '0;
        tick_cnt  <= '0;
      end else if (!options[1]) begin
        state     <= WAIT;
        dim_level <= '0;
        cyc_cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            state    <= WAIT;
            cyc_cnt  <= '0;
            tick_cnt <= '0;
          end
          WAIT: begin
            cyc_cnt  <= tick ? '0 : cyc_cnt + 1'b1;
            tick_cnt <= tick_cnt_next;
            if (tick_cnt_next == TW'(DIM_TICKS)) begin
              state     <= FADE;
              dim_level <= 2'd1;
            end
          end
          FADE: begin
            cyc_cnt  <= tick ? '0 : cyc_cnt + 1'b1;
            tick_cnt <= tick_cnt_next;
            if (tick && (dim_level < 2'(DIM_MAX)))
              dim_level <= dim_level + 1'b1;
          end
          default: begin
            state     <= IDLE;
            dim_level <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pause_fade_ctrl.sv
// Directed bench for pause_fade_ctrl with a short fade timebase.
module tb_pause_fade_ctrl;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic       user_button;
  logic [1:0] pause_request;
  logic       OSD_STATUS;
  logic [1:0] options;
  logic [2:0] r;
  logic [2:0] g;
  logic [1:0] b;
  logic       pause_cpu;
  logic [3:0] pause_src;
  logic [1:0] dim_level;
  logic [7:0] rgb_out;

  int passed = 0;
  int total  = 0;

  always #5 clk_sys = ~clk_sys;

  pause_fade_ctrl #(
    .RW(3), .GW(3), .BW(2), .NREQ(2),
    .TICK_CYCLES(4), .DIM_TICKS(3), .DIM_MAX(2)
  ) dut (
    .clk_sys(clk_sys),
    .reset(reset),
    .user_button(user_button),
    .pause_request(pause_request),
    .OSD_STATUS(OSD_STATUS),
    .options(options),
    .r(r),
    .g(g),
    .b(b),
    .pause_cpu(pause_cpu),
    .pause_src(pause_src),
    .dim_level(dim_level),
    .rgb_out(rgb_out)
  );

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; user_button = 1'b0; pause_request = '0; OSD_STATUS = 1'b0;
    options = 2'b00; r = 3'd7; g = 3'd7; b = 2'd3;
    step(3);
    total++; if (rgb_out !== 8'h00) $display("FAIL reset_rgb got %h want 00", rgb_out); else passed++;
    reset = 1'b0;
    r = 3'd0; g = 3'd0; b = 2'd0;
    step(1);
    total++; if (pause_cpu !== 1'b0) $display("FAIL reset_pause got %b want 0", pause_cpu); else passed++;
    total++; if (pause_src !== 4'b0000) $display("FAIL reset_src got %b want 0000", pause_src); else passed++;
    total++; if (dim_level !== 2'd0) $display("FAIL reset_dim got %0d want 0", dim_level); else passed++;
  endtask

  task automatic test_toggle;
    user_button = 1'b1; step(1);
    total++; if (pause_cpu !== 1'b1) $display("FAIL toggle_on got %b want 1", pause_cpu); else passed++;
    total++; if (pause_src !== 4'b0100) $display("FAIL toggle_on_src got %b want 0100", pause_src); else passed++;
    user_button = 1'b0; step(2);
    total++; if (pause_cpu !== 1'b1) $display("FAIL toggle_hold got %b want 1", pause_cpu); else passed++;
    user_button = 1'b1; step(1);
    total++; if (pause_cpu !== 1'b0) $display("FAIL toggle_off got %b want 0", pause_cpu); else passed++;
    total++; if (pause_src !== 4'b0000) $display("FAIL toggle_off_src got %b want 0000", pause_src); else passed++;
    user_button = 1'b0; step(1);
  endtask

  task automatic test_osd;
    OSD_STATUS = 1'b1; options = 2'b00; step(1);
    total++; if (pause_cpu !== 1'b0) $display("FAIL osd_gated got %b want 0", pause_cpu); else passed++;
    options = 2'b01; step(1);
    total++; if (pause_cpu !== 1'b1) $display("FAIL osd_pause got %b want 1", pause_cpu); else passed++;
    total++; if (pause_src !== 4'b1000) $display("FAIL osd_src got %b want 1000", pause_src); else passed++;
    OSD_STATUS = 1'b0; step(1);
    total++; if (pause_cpu !== 1'b0) $display("FAIL osd_close got %b want 0", pause_cpu); else passed++;
  endtask

  task automatic test_fade;
    options = 2'b11; r = 3'd7; g = 3'd7; b = 2'd3;
    pause_request = 2'b01; step(1);
    total++; if (pause_cpu !== 1'b1) $display("FAIL fade_pause got %b want 1", pause_cpu); else passed++;
    step(11);
    total++; if (dim_level !== 2'd0) $display("FAIL fade_c11 got %0d want 0", dim_level); else passed++;
    step(1);
    total++; if (dim_level !== 2'd1) $display("FAIL fade_c12 got %0d want 1", dim_level); else passed++;
    total++; if (rgb_out !== 8'hFF) $display("FAIL fade_rgb0 got %h want ff", rgb_out); else passed++;
    step(1);
    total++; if (rgb_out !== 8'h6D) $display("FAIL fade_rgb1 got %h want 6d", rgb_out); else passed++;
    step(2);
    total++; if (dim_level !== 2'd1) $display("FAIL fade_c15 got %0d want 1", dim_level); else passed++;
    step(1);
    total++; if (dim_level !== 2'd2) $display("FAIL fade_c16 got %0d want 2", dim_level); else passed++;
    step(1);
    total++; if (rgb_out !== 8'h24) $display("FAIL fade_rgb2 got %h want 24", rgb_out); else passed++;
    step(8);
    total++; if (dim_level !== 2'd2) $display("FAIL fade_sat got %0d want 2", dim_level); else passed++;
    options = 2'b01; step(1);
    total++; if (dim_level !== 2'd0) $display("FAIL fade_disable got %0d want 0", dim_level); else passed++;
    total++; if (pause_cpu !== 1'b1) $display("FAIL fade_disable_pause got %b want 1", pause_cpu); else passed++;
    step(20);
    total++; if (dim_level !== 2'd0) $display("FAIL fade_off_hold got %0d want 0", dim_level); else passed++;
    pause_request = 2'b00; options = 2'b11; step(1);
  endtask

  task automatic test_unpause;
    pause_request = 2'b01; step(1);
    step(12);
    total++; if (dim_level !== 2'd1) $display("FAIL unp_dim1 got %0d want 1", dim_level); else passed++;
    pause_request = 2'b00; step(1);
    total++; if (pause_cpu !== 1'b0) $display("FAIL unp_pause got %b want 0", pause_cpu); else passed++;
    total++; if (dim_level !== 2'd0) $display("FAIL unp_dim got %0d want 0", dim_level); else passed++;
    step(1);
    total++; if (rgb_out !== 8'hFF) $display("FAIL unp_rgb got %h want ff", rgb_out); else passed++;
  endtask

  task automatic test_overlap;
    user_button = 1'b1; step(1);
    user_button = 1'b0; pause_request = 2'b10; step(1);
    total++; if (pause_src !== 4'b0110) $display("FAIL ovl_both got %b want 0110", pause_src); else passed++;
    user_button = 1'b1; step(1);
    total++; if (pause_cpu !== 1'b1) $display("FAIL ovl_pause got %b want 1", pause_cpu); else passed++;
    total++; if (pause_src !== 4'b0010) $display("FAIL ovl_src got %b want 0010", pause_src); else passed++;
    user_button = 1'b0; pause_request = 2'b00; step(1);
    total++; if (pause_cpu !== 1'b0) $display("FAIL ovl_release got %b want 0", pause_cpu); else passed++;
    total++; if (pause_src !== 4'b0000) $display("FAIL ovl_release_src got %b want 0000", pause_src); else passed++;
  endtask

  task automatic test_reset_button;
    user_button = 1'b1; pause_request = 2'b01; step(5);
    reset = 1'b1; step(2);
    total++; if (dim_level !== 2'd0) $display("FAIL rstb_dim got %0d want 0", dim_level); else passed++;
    pause_request = 2'b00; reset = 1'b0; step(1);
    total++; if (pause_cpu !== 1'b0) $display("FAIL rstb_after got %b want 0", pause_cpu); else passed++;
    step(3);
    total++; if (pause_cpu !== 1'b0) $display("FAIL rstb_held got %b want 0", pause_cpu); else passed++;
    user_button = 1'b0; step(1);
    total++; if (pause_cpu !== 1'b0) $display("FAIL rstb_fall got %b want 0", pause_cpu); else passed++;
    user_button = 1'b1; step(1);
    total++; if (pause_cpu !== 1'b1) $display("FAIL rstb_rise got %b want 1", pause_cpu); else passed++;
    total++; if (pause_src !== 4'b0100) $display("FAIL rstb_src got %b want 0100", pause_src); else passed++;
    user_button = 1'b0; step(1);
  endtask

  initial begin
    test_reset;
    test_toggle;
    test_osd;
    test_fade;
    test_unpause;
    test_overlap;
    test_reset_button;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
